// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end.
// Fetch-queue entries pair an instruction with its PC+4.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries.
// Flush empties it in one cycle; storage itself is never cleared.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    // Pointer and occupancy bookkeeping; flush restarts from slot 0.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Entry storage; a flushed write is dropped.
    always_ff @(posedge CLK) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: owns the PC, issues imem reads under a credit
// limit and queues returned words with their PC+4 for decode.
module if_fetch_queue
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_next_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_npc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW-1:0]   credit;
    logic            push;
    logic            pop;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            unused_bits;

    // Outstanding words (buffered plus in flight) must leave room.
    assign credit   = count + {{(CW-1){1'b0}}, inflight};
    assign imem_req = !reset && !redirect && (credit < CW'(DEPTH));
    assign imem_addr = pc[ADDR_W+1:2];

    assign push      = inflight && !redirect;
    assign pop       = if_valid && !id_stall;
    assign push_data = '{instr: imem_rdata, npc: inflight_npc};

    // PC advance, redirect reload and in-flight tracking.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_npc <= '0;
        end else if (redirect) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else if (imem_req) begin
            pc           <= pc + 32'd4;
            inflight     <= 1'b1;
            inflight_npc <= pc + 32'd4;
        end else begin
            inflight <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

    assign if_valid   = (count != '0);
    assign if_instr   = if_valid ? head.instr : INSTR_NOP;
    assign if_next_pc = if_valid ? head.npc : 32'h0;

    assign unused_bits = ^{redirect_pc[1:0], pc[31:ADDR_W+2], pc[1:0]};

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized scoreboard bench for if_fetch_queue.
// Expected words come from a stream model of PC order and 2-cycle latency.
module tb_if_fetch_queue;
    import mips_pkg::*;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 7;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic              CLK;
    logic              reset;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              id_stall;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [31:0]       if_next_pc;

    if_fetch_queue #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .RESET_PC    (RST_PC)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_next_pc  (if_next_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'(a) * 32'h11;
    endfunction

    // Synchronous instruction memory, one cycle of latency.
    always @(posedge CLK) imem_rdata <= mem_word(imem_addr);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] exp_pc = RST_PC;
    int          cyc = 0;
    int          vectors = 0;
    int          misc = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: compare outputs against the stream model, then advance it.
    always @(negedge CLK) begin
        bit          ev;
        bit          er;
        logic [31:0] ea;
        if (reset) begin
            q.delete();
            exp_pc = RST_PC;
            ev = 1'b0;
            er = 1'b0;
        end else begin
            ev = (q.size() > 0) && (q[0].t + 2 <= cyc);
            er = !redirect && (q.size() < DEPTH);
        end
        chk("if_valid", 32'(if_valid), 32'(ev));
        chk("imem_req", 32'(imem_req), 32'(er));
        if (ev) begin
            chk("if_instr", if_instr, q[0].instr);
            chk("if_next_pc", if_next_pc, q[0].npc);
        end else begin
            chk("nop_instr", if_instr, 32'h0);
            chk("nop_next_pc", if_next_pc, 32'h0);
        end
        ea = {25'h0, exp_pc[ADDR_W+1:2]};
        if (er) chk("imem_addr", 32'(imem_addr), ea);
        if (!reset) begin
            if (ev && !id_stall) void'(q.pop_front());
            if (redirect) begin
                q.delete();
                exp_pc = {redirect_pc[31:2], 2'b00};
            end else if (er) begin
                q.push_back('{mem_word(exp_pc[ADDR_W+1:2]),
                              exp_pc + 32'd4, cyc});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_stall    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();

        id_stall = 1'b1;
        repeat (10) tick();
        chk("full_no_req", 32'(imem_req), 32'h0);
        chk("full_valid", 32'(if_valid), 32'h1);
        id_stall = 1'b0;
        repeat (10) tick();

        id_stall = 1'b1;
        repeat (2) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        redirect = 1'b0;
        id_stall = 1'b0;
        repeat (10) tick();

        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        repeat (8) tick();

        for (int i = 0; i < 600; i++) begin
            id_stall = ($urandom % 10) < 3;
            redirect = ($urandom % 20) == 0;
            if (($urandom % 4) == 0)
                redirect_pc = 32'hFFFF_FFF0 + ($urandom % 16);
            else
                redirect_pc = $urandom;
            tick();
        end
        redirect = 1'b0;
        id_stall = 1'b0;
        repeat (6) tick();

        @(posedge CLK);
        #3;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(if_valid), 32'h0);
        chk("async_req", 32'(imem_req), 32'h0);
        chk("async_instr", if_instr, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
